// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port synchronous VRAM (1-cycle read latency) between the
//   display scan-out fetch (absolute priority, fixed latency 2) and a CPU bus
//   using a req/ack handshake that is served in RAM cycles the display leaves
//   free. A sticky flag reports CPU starvation.
//
// Ports
//   pclk, reset_n                     pixel clock, async active-low reset
//   vid_req/vid_addr                  display fetch request (one per cycle max)
//   vid_data/vid_valid                fetched byte, valid two cycles after vid_req
//   cpu_req/cpu_we/cpu_addr/cpu_wdata CPU request, held stable until cpu_ack
//   cpu_ack/cpu_rdata                 completion pulse, read data (held)
//   cpu_starve                        sticky starvation flag
//   ram_addr/ram_we/ram_wdata         RAM port, combinational from the grant
//   ram_rdata                         RAM read data, valid cycle after address
//
// state  | meaning
// C_IDLE | no CPU transfer in flight; may grant a new request
// C_WAIT | CPU request pending, denied by display traffic
// C_RD   | read issued last cycle; capture ram_rdata this cycle
// C_ACK  | cpu_ack pulse cycle; no grant so a held cpu_req cannot re-issue

module vram_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 8,
    parameter int STARVE_LIM = 64
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_starve,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RD, C_ACK} cpu_state_t;

    localparam logic [7:0] LP_LIM = 8'(STARVE_LIM);

    cpu_state_t    r_state;
    logic [AW-1:0] r_ram_addr;
    logic          r_vid_p1;
    logic [DW-1:0] r_vid_data;
    logic          r_vid_valid;
    logic          r_cpu_ack;
    logic [DW-1:0] r_cpu_rdata;
    logic          r_cpu_starve;
    logic [7:0]    r_starve_cnt;

    logic          w_cpu_pend;
    logic          w_cpu_gnt;
    logic          w_cpu_deny;
    logic [7:0]    w_cnt_nxt;

    assign w_cpu_pend = cpu_req && ((r_state == C_IDLE) || (r_state == C_WAIT));
    assign w_cpu_gnt  = w_cpu_pend && !vid_req;
    assign w_cpu_deny = w_cpu_pend && vid_req;

    // Idle cycles keep the last address on the bus to avoid needless toggling.
    assign ram_addr  = vid_req ? vid_addr : (w_cpu_gnt ? cpu_addr : r_ram_addr);
    assign ram_we    = reset_n && w_cpu_gnt && cpu_we;
    assign ram_wdata = cpu_wdata;

    assign vid_data   = r_vid_data;
    assign vid_valid  = r_vid_valid;
    assign cpu_ack    = r_cpu_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_starve = r_cpu_starve;

    always_comb begin
        w_cnt_nxt = r_starve_cnt;
        if (w_cpu_gnt)
            w_cnt_nxt = 8'd0;
        else if (w_cpu_deny && (r_starve_cnt != 8'hFF))
            w_cnt_nxt = r_starve_cnt + 8'd1;
    end

    // Display pipeline: request in t, RAM data arrives in t+1, registered for t+2.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_addr  <= '0;
            r_vid_p1    <= 1'b0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_ram_addr  <= ram_addr;
            r_vid_p1    <= vid_req;
            r_vid_valid <= r_vid_p1;
            if (r_vid_p1)
                r_vid_data <= ram_rdata;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= C_IDLE;
            r_cpu_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_starve_cnt <= 8'd0;
            r_cpu_starve <= 1'b0;
        end else begin
            r_cpu_ack    <= 1'b0;
            r_starve_cnt <= w_cnt_nxt;
            if (w_cpu_deny && (w_cnt_nxt >= LP_LIM))
                r_cpu_starve <= 1'b1;
            case (r_state)
                C_IDLE, C_WAIT: begin
                    if (w_cpu_gnt) begin
                        r_state   <= cpu_we ? C_ACK : C_RD;
                        r_cpu_ack <= cpu_we;
                    end else if (cpu_req) begin
                        r_state <= C_WAIT;
                    end else begin
                        r_state <= C_IDLE;
                    end
                end
                C_RD: begin
                    r_cpu_rdata <= ram_rdata;
                    r_cpu_ack   <= 1'b1;
                    r_state     <= C_ACK;
                end
                C_ACK:   r_state <= C_IDLE;
                default: r_state <= C_IDLE;
            endcase
        end
    end

endmodule
